// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: state encoding and framing constants shared by uart_tx_scheduler.
package uart_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, SEND = 2'd2, GAP = 2'd3} state_e;
  localparam logic [4:0] HDR_TAG = 5'b10100;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [2:0]                 idx_o
);
  localparam int IW = $clog2(NUM_REQ);
  // Scan farthest offset first so the nearest requester to ptr_i is written last and wins.
  always_comb begin
    logic [IW-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = 3'(j);
      end
    end
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin shares one UART byte transmitter among NUM_REQ 32-bit word producers.
// Define UART_SCHED_HDR_EN to prefix every frame with header byte 0xA0|grant_id.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [7:0]            tx_byte,
  output logic                  tx_byte_valid,
  input  logic                  tx_byte_ready,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int IW = $clog2(NUM_REQ);
  state_e        state_q;
  logic [31:0]   word_q;
  logic [1:0]    idx_q;
  logic [7:0]    gap_q;
  logic [7:0]    tx_byte_q;
  logic [IW-1:0] rr_ptr_q;
  logic [2:0]    grant_id_q;
  logic          tx_valid_q;
  logic          frame_done_q;
  logic [NUM_REQ-1:0] gnt;
  logic [2:0]    gidx;
  logic [IW-1:0] gsel;
  logic [31:0]   gword;
  logic [1:0]    idx_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );
  assign gsel          = gidx[IW-1:0];
  assign gword         = req_data[{gsel, 5'd0} +: 32];
  assign idx_d         = idx_q - 2'd1;
  assign req_ready     = (state_q == IDLE && reset_n) ? gnt : '0;
  assign tx_byte       = tx_byte_q;
  assign tx_byte_valid = tx_valid_q;
  assign grant_id      = grant_id_q;
  assign busy          = state_q != IDLE;
  assign frame_done    = frame_done_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      tx_byte_q    <= '0;
      tx_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: if (|req_valid) begin
          word_q     <= gword;
          grant_id_q <= gidx;
          rr_ptr_q   <= (gsel == IW'(NUM_REQ - 1)) ? '0 : gsel + 1'b1;
          tx_valid_q <= 1'b1;
          idx_q      <= 2'(BYTES_PER_WORD - 1);
`ifdef UART_SCHED_HDR_EN
          state_q    <= HDR;
          tx_byte_q  <= {HDR_TAG, gidx};
`else
          state_q    <= SEND;
          tx_byte_q  <= gword[31:24];
`endif
        end
`ifdef UART_SCHED_HDR_EN
        HDR: if (tx_byte_ready) begin
          state_q   <= SEND;
          tx_byte_q <= word_q[31:24];
        end
`endif
        SEND: if (tx_byte_ready) begin
          if (idx_q == 2'd0) begin
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b1;
            gap_q        <= 8'(GAP_CYCLES - 1);
            state_q      <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            idx_q     <= idx_d;
            tx_byte_q <= word_q[{idx_d, 3'd0} +: 8];
          end
        end
        GAP: if (gap_q == 8'd0) state_q <= IDLE; else gap_q <= gap_q - 8'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench; stimulus queues expected grants/bytes, a monitor pops and compares.
module tb_uart_tx_scheduler;
  localparam int N = 4;
`ifdef UART_SCHED_HDR_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic [7:0] tx_byte;
  logic tx_byte_valid;
  logic tx_byte_ready = 1'b0;
  logic [2:0] grant_id;
  logic busy, frame_done;

  uart_tx_scheduler #(.NUM_REQ(N), .GAP_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid),
    .tx_byte_ready(tx_byte_ready), .grant_id(grant_id), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] b; logic [2:0] gid; logic last;} exp_t;
  exp_t bq[$];
  int gq[$];
  int checks = 0, errors = 0, acc = 0, gcnt = 0, fdcnt = 0;
  bit bp = 1'b0;
  bit pend = 1'b0, gpend = 1'b0;
  int fde = -1;
  logic [7:0] held;
  exp_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int g, input logic [31:0] w);
    gq.push_back(g);
`ifdef UART_SCHED_HDR_EN
    bq.push_back('{8'hA0 | 8'(g), 3'(g), 1'b0});
`endif
    for (int i = 3; i >= 0; i--) bq.push_back('{8'(w >> (8 * i)), 3'(g), i == 0});
  endtask

  task automatic wait_grants(input int n);
    int t = 0;
    while (gcnt < n && t < 2000) begin @(posedge clk); t++; end
    chk("grant_wait", 32'(gcnt >= n), 1);
  endtask

  task automatic wait_fd(input int n);
    int t = 0;
    while (fdcnt < n && t < 2000) begin @(posedge clk); t++; end
    chk("frame_done_wait", 32'(fdcnt >= n), 1);
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc < n && t < 2000) begin @(posedge clk); t++; end
    chk("accept_wait", 32'(acc >= n), 1);
  endtask

  // Ready driver: always ready, or 1-of-3 cycles under backpressure.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      tx_byte_ready = bp ? (cyc % 3 == 0) : 1'b1;
    end
  end

  // Monitor: grants, byte accepts, hold stability, frame_done and first-byte latency.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0; gpend = 1'b0; fde = -1;
        continue;
      end
      if (frame_done) fdcnt++;
      if (fde >= 0) begin chk("frame_done", 32'(frame_done), fde); fde = -1; end
      if (gpend) begin chk("grant_to_valid", 32'(tx_byte_valid), 1); gpend = 1'b0; end
      if (pend) begin
        chk("hold_valid", 32'(tx_byte_valid), 1);
        chk("hold_byte", 32'(tx_byte), 32'(held));
        pend = 1'b0;
      end
      if (req_ready != '0) begin
        chk("req_ready_onehot", 32'($onehot(req_ready)), 1);
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got req_ready %0h expected none", req_ready);
        end else begin
          int g;
          g = gq.pop_front();
          chk("grant", 32'(req_ready), 32'(1) << g);
        end
        gcnt++;
        gpend = 1'b1;
      end
      if (tx_byte_valid && tx_byte_ready) begin
        acc++;
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_byte);
        end else begin
          e = bq.pop_front();
          chk("byte", 32'(tx_byte), 32'(e.b));
          chk("grant_id", 32'(grant_id), 32'(e.gid));
          fde = int'(e.last);
        end
      end else if (tx_byte_valid) begin
        pend = 1'b1;
        held = tx_byte;
      end
    end
  end

  initial begin
    int n;
    int a0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_byte_valid), 0);
    chk("rst_tx_byte", 32'(tx_byte), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    // Single word from requester 0, then count the inter-frame gap.
    req_data[31:0] = 32'hDEADBEEF;
    push_frame(0, 32'hDEADBEEF);
    req_valid = 4'b0001;
    wait_grants(1); #1;
    req_valid = '0;
    wait_fd(1);
    n = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("gap_busy_after_done", 32'(n), 15);
    chk("t1_queue_empty", 32'(bq.size()), 0);
    // Backpressure on requester 1.
    @(posedge clk); #1;
    bp = 1'b1;
    req_data[63:32] = 32'h11223344;
    push_frame(1, 32'h11223344);
    req_valid = 4'b0010;
    wait_grants(2); #1;
    req_valid = '0;
    wait_fd(2);
    chk("bp_queue_empty", 32'(bq.size()), 0);
    bp = 1'b0;
    // Requester 2 alone; also leaves rr_ptr at 3.
    #1;
    req_data[95:64] = 32'h01020304;
    push_frame(2, 32'h01020304);
    req_valid = 4'b0100;
    wait_grants(3); #1;
    req_valid = '0;
    wait_fd(3);
    chk("r2_queue_empty", 32'(bq.size()), 0);
    // Wrap: pointer at 3 with only 1 and 2 requesting.
    #1;
    push_frame(1, 32'h11223344);
    push_frame(2, 32'h01020304);
    req_valid = 4'b0110;
    wait_fd(5); #1;
    req_valid = '0;
    chk("wrap_grants", 32'(gcnt), 5);
    chk("wrap_queue_empty", 32'(bq.size()), 0);
    // Reset after the second data byte of requester 3 is accepted.
    req_data[127:96] = 32'hCAFEF00D;
    gq.push_back(3);
`ifdef UART_SCHED_HDR_EN
    bq.push_back('{8'hA3, 3'd3, 1'b0});
`endif
    bq.push_back('{8'hCA, 3'd3, 1'b0});
    bq.push_back('{8'hFE, 3'd3, 1'b0});
    a0 = acc;
    req_valid = 4'b1000;
    wait_acc(a0 + 2 + HB);
    #1;
    reset_n = 1'b0;
    req_valid = '0;
    #1;
    chk("arst_tx_valid", 32'(tx_byte_valid), 0);
    chk("arst_tx_byte", 32'(tx_byte), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_grant_id", 32'(grant_id), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_valid", 32'(tx_byte_valid), 0);
    chk("post_rst_queue_empty", 32'(bq.size()), 0);
    // Fairness from rr_ptr=0 with all requesters valid for 8 frames.
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'h11111111 * (i + 1);
    for (int f = 0; f < 8; f++) push_frame(f % N, 32'h11111111 * ((f % N) + 1));
    req_valid = 4'b1111;
    wait_fd(13); #1;
    req_valid = '0;
    chk("fair_grants_left", 32'(gq.size()), 0);
    chk("fair_bytes_left", 32'(bq.size()), 0);
    repeat (30) @(posedge clk);
    chk("final_grants", 32'(gcnt), 14);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
